// File: rtl/nes_bus_pkg.sv
// Shared types and defaults for the NES CPU-bus DMA arbitration blocks.
package nes_bus_pkg;

  typedef enum logic {
    ARB_CPU,
    ARB_MST
  } arb_state_e;

  localparam int NES_AW = 16;
  localparam int NES_DW = 8;

  // Internal RAM: a dummy read here has no side effects on any device.
  localparam logic [15:0] NES_IDLE_ADDR = 16'h0000;

endpackage

// File: rtl/nes_arb_pick.sv
// Combinational winner selection for the DMA arbiter.
// NES_DMA_ARB_RR_EN selects round-robin after ptr; otherwise lowest index wins.
module nes_arb_pick #(
  parameter int N_MST = 2,
  parameter int IW    = 1
) (
  input  logic [N_MST-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_MST-1:0] win_oh,
  output logic [IW-1:0]    win_idx
);

`ifdef NES_DMA_ARB_RR_EN
  always_comb begin
    logic          found;
    logic [IW-1:0] j;
    found   = 1'b0;
    win_idx = '0;
    j       = '0;
    // Scan starts one past the last-granted index and wraps.
    for (int i = 1; i <= N_MST; i++) begin
      j = IW'((int'(ptr) + i) % N_MST);
      if (!found && req[j]) begin
        found   = 1'b1;
        win_idx = j;
      end
    end
    win_oh = '0;
    if (found) win_oh[win_idx] = 1'b1;
  end
`else
  always_comb begin
    logic [IW-1:0] j;
    win_idx = '0;
    j       = '0;
    for (int i = N_MST - 1; i >= 0; i--) begin
      j = IW'(i);
      if (req[j]) win_idx = j;
    end
    win_oh = '0;
    if (|req) win_oh[win_idx] = 1'b1;
  end

  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

endmodule

// File: rtl/nes_dma_arbiter.sv
// CPU-bus master arbiter: halts the 6502 and grants the bus to one of N_MST DMA masters.
// Build macro NES_DMA_ARB_RR_EN enables round-robin selection (default: fixed priority).
//
// state   | meaning
// ARB_CPU | CPU owns the bus; masters wait for a CPU read cycle
// ARB_MST | master cur owns the bus; CPU paused
module nes_dma_arbiter
  import nes_bus_pkg::*;
#(
  parameter int            N_MST     = 2,
  parameter int            AW        = NES_AW,
  parameter int            DW        = NES_DW,
  parameter int            HOLD_MAX  = 0,
  parameter logic [AW-1:0] IDLE_ADDR = AW'(NES_IDLE_ADDR)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [AW-1:0]       i_cpu_addr,
  input  logic                i_cpu_r_wn,
  input  logic [DW-1:0]       i_cpu_wdata,
  output logic [DW-1:0]       o_cpu_rdata,
  output logic                o_cpu_pause,
  input  logic [N_MST-1:0]    i_m_req,
  output logic [N_MST-1:0]    o_m_gnt,
  input  logic [N_MST*AW-1:0] i_m_addr,
  input  logic [N_MST-1:0]    i_m_wn,
  input  logic [N_MST*DW-1:0] i_m_wdata,
  output logic [DW-1:0]       o_m_rdata,
  output logic [N_MST-1:0]    o_m_rvalid,
  output logic [AW-1:0]       o_bus_addr,
  output logic [DW-1:0]       o_bus_wdata,
  output logic                o_bus_wn,
  input  logic [DW-1:0]       i_bus_rdata
);

  localparam int IW       = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam int HOLD_TOP = (HOLD_MAX > 0) ? HOLD_MAX - 1 : 0;
  localparam int HW       = (HOLD_TOP > 0) ? $clog2(HOLD_TOP + 1) : 1;

  arb_state_e       state_q;
  logic [IW-1:0]    cur_q;
  logic [N_MST-1:0] gnt_q;
  logic [HW-1:0]    hold_q;

  logic [N_MST-1:0] pick_req;
  logic [N_MST-1:0] win_oh;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    ptr;
  logic             others;
  logic             cur_req;
  logic             cur_wn;
  logic             hold_hit;
  logic             release_now;
  logic             grant_load;

  // gnt_q is zero in ARB_CPU, so this masks out only the current owner.
  assign pick_req    = i_m_req & ~gnt_q;
  assign others      = |pick_req;
  assign cur_req     = i_m_req[cur_q];
  assign cur_wn      = i_m_wn[cur_q];
  assign hold_hit    = (HOLD_MAX != 0) && (hold_q == HW'(HOLD_TOP));
  assign release_now = !cur_req || (hold_hit && others);
  assign grant_load  = others && (((state_q == ARB_CPU) && i_cpu_r_wn) ||
                                  ((state_q == ARB_MST) && release_now));

  nes_arb_pick #(
    .N_MST (N_MST),
    .IW    (IW)
  ) u_pick (
    .req     (pick_req),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

`ifdef NES_DMA_ARB_RR_EN
  logic [IW-1:0] ptr_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)           ptr_q <= IW'(N_MST - 1);
    else if (grant_load) ptr_q <= win_idx;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ARB_CPU;
      cur_q       <= '0;
      gnt_q       <= '0;
      o_cpu_pause <= 1'b0;
      hold_q      <= '0;
    end else begin
      case (state_q)
        ARB_CPU: begin
          if (grant_load) begin
            state_q     <= ARB_MST;
            cur_q       <= win_idx;
            gnt_q       <= win_oh;
            o_cpu_pause <= 1'b1;
            hold_q      <= '0;
          end
        end
        ARB_MST: begin
          if (grant_load) begin
            // Direct handoff: pause stays high, no CPU cycle in between.
            cur_q  <= win_idx;
            gnt_q  <= win_oh;
            hold_q <= '0;
          end else if (release_now) begin
            state_q     <= ARB_CPU;
            gnt_q       <= '0;
            o_cpu_pause <= 1'b0;
            hold_q      <= '0;
          end else if ((HOLD_MAX != 0) && !hold_hit) begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= ARB_CPU;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_m_rdata  <= '0;
      o_m_rvalid <= '0;
    end else if ((state_q == ARB_MST) && cur_req && cur_wn) begin
      o_m_rdata  <= i_bus_rdata;
      o_m_rvalid <= gnt_q;
    end else begin
      o_m_rvalid <= '0;
    end
  end

  always_comb begin
    o_bus_addr  = i_cpu_addr;
    o_bus_wdata = i_cpu_wdata;
    o_bus_wn    = i_cpu_r_wn;
    if (state_q == ARB_MST) begin
      if (cur_req) begin
        o_bus_addr  = i_m_addr[int'(cur_q)*AW +: AW];
        o_bus_wdata = i_m_wdata[int'(cur_q)*DW +: DW];
        o_bus_wn    = cur_wn;
      end else begin
        o_bus_addr  = IDLE_ADDR;
        o_bus_wdata = '0;
        o_bus_wn    = 1'b1;
      end
    end
  end

  assign o_m_gnt     = gnt_q;
  assign o_cpu_rdata = i_bus_rdata;

endmodule

// File: tb/tb_nes_dma_arbiter.sv
// Directed self-checking bench for nes_dma_arbiter (N_MST=2, HOLD_MAX=4).
module tb_nes_dma_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_r_wn;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_pause;
  logic [1:0]  m_req;
  logic [1:0]  m_gnt;
  logic [31:0] m_addr;
  logic [1:0]  m_wn;
  logic [15:0] m_wdata;
  logic [7:0]  m_rdata;
  logic [1:0]  m_rvalid;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_wn;
  logic [7:0]  bus_rdata;

  int checks = 0;
  int errors = 0;
  int first_w;
  int own;
  int prev;

  always #5 clk = ~clk;

  nes_dma_arbiter #(
    .N_MST    (2),
    .AW       (16),
    .DW       (8),
    .HOLD_MAX (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_r_wn  (cpu_r_wn),
    .i_cpu_wdata (cpu_wdata),
    .o_cpu_rdata (cpu_rdata),
    .o_cpu_pause (cpu_pause),
    .i_m_req     (m_req),
    .o_m_gnt     (m_gnt),
    .i_m_addr    (m_addr),
    .i_m_wn      (m_wn),
    .i_m_wdata   (m_wdata),
    .o_m_rdata   (m_rdata),
    .o_m_rvalid  (m_rvalid),
    .o_bus_addr  (bus_addr),
    .o_bus_wdata (bus_wdata),
    .o_bus_wn    (bus_wn),
    .i_bus_rdata (bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef NES_DMA_ARB_RR_EN
    first_w = 1;
`else
    first_w = 0;
`endif
    rst       = 1'b1;
    cpu_addr  = 16'h8000;
    cpu_r_wn  = 1'b1;
    cpu_wdata = 8'h00;
    m_req     = 2'b00;
    m_addr    = {16'h0200, 16'h0300};
    m_wn      = 2'b11;
    m_wdata   = {8'hB1, 8'hA0};
    bus_rdata = 8'h5A;

    #2;
    chk("rst_pause", 32'(cpu_pause), 32'd0);
    chk("rst_gnt", 32'(m_gnt), 32'd0);
    chk("rst_rvalid", 32'(m_rvalid), 32'd0);
    chk("rst_rdata", 32'(m_rdata), 32'd0);
    chk("rst_bus_addr", 32'(bus_addr), 32'h8000);
    chk("rst_bus_wn", 32'(bus_wn), 32'd1);
    #10 rst = 1'b0;

    // single-master read by master 1
    m_req = 2'b10;
    tick();
    chk("rd_gnt", 32'(m_gnt), 32'b10);
    chk("rd_pause", 32'(cpu_pause), 32'd1);
    chk("rd_bus_addr", 32'(bus_addr), 32'h0200);
    chk("rd_bus_wn", 32'(bus_wn), 32'd1);
    tick();
    chk("rd_rvalid", 32'(m_rvalid), 32'b10);
    chk("rd_rdata", 32'(m_rdata), 32'h5A);
    bus_rdata = 8'h11;
    m_req = 2'b00;
    #1;
    chk("cpu_rdata_pass", 32'(cpu_rdata), 32'h11);
    chk("rd_rdata_held", 32'(m_rdata), 32'h5A);
    chk("idle_bus_addr", 32'(bus_addr), 32'h0000);
    chk("idle_bus_wn", 32'(bus_wn), 32'd1);
    tick();
    chk("rel_gnt", 32'(m_gnt), 32'd0);
    chk("rel_pause", 32'(cpu_pause), 32'd0);
    chk("rel_rvalid", 32'(m_rvalid), 32'd0);
    chk("rel_bus_addr", 32'(bus_addr), 32'h8000);
    cpu_r_wn  = 1'b0;
    cpu_wdata = 8'h33;
    #1;
    chk("rel_bus_wn", 32'(bus_wn), 32'd0);
    chk("rel_bus_wdata", 32'(bus_wdata), 32'h33);

    // request during CPU writes is held off
    m_req = 2'b01;
    tick();
    chk("wr_hold1_gnt", 32'(m_gnt), 32'd0);
    chk("wr_hold1_pause", 32'(cpu_pause), 32'd0);
    tick();
    chk("wr_hold2_gnt", 32'(m_gnt), 32'd0);
    cpu_r_wn = 1'b1;
    tick();
    chk("wr_gnt", 32'(m_gnt), 32'b01);
    chk("wr_pause", 32'(cpu_pause), 32'd1);
    chk("wr_bus_addr", 32'(bus_addr), 32'h0300);
    m_wn = 2'b10;
    #1;
    chk("mwr_bus_wn", 32'(bus_wn), 32'd0);
    chk("mwr_bus_wdata", 32'(bus_wdata), 32'hA0);
    tick();
    chk("mwr_rvalid", 32'(m_rvalid), 32'd0);
    m_req = 2'b00;
    m_wn  = 2'b11;
    tick();
    chk("wr_rel_gnt", 32'(m_gnt), 32'd0);

    // asynchronous reset in the middle of a grant
    m_req = 2'b10;
    tick();
    chk("pre_rst_gnt", 32'(m_gnt), 32'b10);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_gnt", 32'(m_gnt), 32'd0);
    chk("async_rst_pause", 32'(cpu_pause), 32'd0);
    chk("async_rst_rvalid", 32'(m_rvalid), 32'd0);
    chk("async_rst_rdata", 32'(m_rdata), 32'd0);
    chk("async_rst_bus_addr", 32'(bus_addr), 32'h8000);
    #1 rst = 1'b0;

    // first contention after reset goes to master 0, then handoff to 1
    m_req = 2'b11;
    tick();
    chk("c1_gnt", 32'(m_gnt), 32'b01);
    chk("c1_pause", 32'(cpu_pause), 32'd1);
    m_req = 2'b10;
    tick();
    chk("handoff_gnt", 32'(m_gnt), 32'b10);
    chk("handoff_pause", 32'(cpu_pause), 32'd1);
    chk("handoff_rvalid", 32'(m_rvalid), 32'd0);
    m_req = 2'b00;
    tick();
    chk("c1_rel_gnt", 32'(m_gnt), 32'd0);
    m_req = 2'b01;
    tick();
    chk("solo0_gnt", 32'(m_gnt), 32'b01);
    m_req = 2'b00;
    tick();
    chk("solo0_rel", 32'(m_gnt), 32'd0);

    // second contention with both streaming: 4-cycle alternating grants
    m_req = 2'b11;
    for (int k = 0; k < 16; k++) begin
      tick();
      own = ((k / 4) % 2 == 0) ? first_w : 1 - first_w;
      chk("hold_gnt", 32'(m_gnt), 32'd1 << own);
      chk("hold_pause", 32'(cpu_pause), 32'd1);
      chk("hold_bus_addr", 32'(bus_addr), (own == 1) ? 32'h0200 : 32'h0300);
      if (k > 0) begin
        prev = (((k - 1) / 4) % 2 == 0) ? first_w : 1 - first_w;
        chk("hold_rvalid", 32'(m_rvalid), 32'd1 << prev);
        chk("hold_rdata", 32'(m_rdata), 32'h11);
      end
    end
    m_req = 2'b00;
    tick();
    chk("end_gnt", 32'(m_gnt), 32'd0);
    chk("end_pause", 32'(cpu_pause), 32'd0);
    chk("end_rvalid", 32'(m_rvalid), 32'd0);
    chk("end_bus_addr", 32'(bus_addr), 32'h8000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
